// File: rtl/mc_cpu_pkg.sv
// Shared types and encodings for the multi-cycle CPU control path: FSM
// states, instruction classes, opcode/func fields, ALU function codes and
// the operand/PC source select values.
package mc_cpu_pkg;

    // Byte increment the datapath applies to PC in IF (alusrcb = 01 selects it)
    localparam int unsigned PC_INC = 32'd4;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        CL_R_ALU   = 4'd0,
        CL_SHIFT   = 4'd1,
        CL_I_ALU   = 4'd2,
        CL_LW      = 4'd3,
        CL_SW      = 4'd4,
        CL_BEQ     = 4'd5,
        CL_BNE     = 4'd6,
        CL_J       = 4'd7,
        CL_JAL     = 4'd8,
        CL_JR      = 4'd9,
        CL_ILLEGAL = 4'd10
    } iclass_t;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function fields (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_HAM = 6'b111000;

    // ALU function codes; don't-care bits are driven as 0
    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;
    localparam logic [3:0] ALUC_HAM = 4'b1011;

    // ALU B operand selects
    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_INC = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_BR  = 2'b11;

    // PC source selects
    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_REGA   = 2'b11;

endpackage

// File: rtl/mc_decoder.sv
// Combinational instruction decoder: op/func -> instruction class, ALU
// function code, immediate extension mode and illegal flag.
// Optional build macro: HAMMING_EN (R-type func 111000 decodes as HAM).
module mc_decoder
    import mc_cpu_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output iclass_t    iclass,
    output logic [3:0] aluc,
    output logic       sext,
    output logic       illegal
);

    // Classify the instruction and pick its ALU function and extension mode
    always_comb begin
        iclass = CL_ILLEGAL;
        aluc   = ALUC_ADD;
        sext   = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (func)
                    FN_ADD: begin iclass = CL_R_ALU; aluc = ALUC_ADD; end
                    FN_SUB: begin iclass = CL_R_ALU; aluc = ALUC_SUB; end
                    FN_AND: begin iclass = CL_R_ALU; aluc = ALUC_AND; end
                    FN_OR:  begin iclass = CL_R_ALU; aluc = ALUC_OR;  end
                    FN_XOR: begin iclass = CL_R_ALU; aluc = ALUC_XOR; end
                    FN_SLL: begin iclass = CL_SHIFT; aluc = ALUC_SLL; end
                    FN_SRL: begin iclass = CL_SHIFT; aluc = ALUC_SRL; end
                    FN_SRA: begin iclass = CL_SHIFT; aluc = ALUC_SRA; end
                    FN_JR:  begin iclass = CL_JR;    aluc = ALUC_ADD; end
`ifdef HAMMING_EN
                    FN_HAM: begin iclass = CL_R_ALU; aluc = ALUC_HAM; end
`else
                    FN_HAM: begin iclass = CL_ILLEGAL; aluc = ALUC_ADD; end
`endif
                    default: begin iclass = CL_ILLEGAL; aluc = ALUC_ADD; end
                endcase
            end
            OP_ADDI: begin iclass = CL_I_ALU; aluc = ALUC_ADD; sext = 1'b1; end
            OP_ANDI: begin iclass = CL_I_ALU; aluc = ALUC_AND; sext = 1'b0; end
            OP_ORI:  begin iclass = CL_I_ALU; aluc = ALUC_OR;  sext = 1'b0; end
            OP_XORI: begin iclass = CL_I_ALU; aluc = ALUC_XOR; sext = 1'b0; end
            OP_LUI:  begin iclass = CL_I_ALU; aluc = ALUC_LUI; sext = 1'b0; end
            OP_LW:   begin iclass = CL_LW;    aluc = ALUC_ADD; sext = 1'b1; end
            OP_SW:   begin iclass = CL_SW;    aluc = ALUC_ADD; sext = 1'b1; end
            OP_BEQ:  begin iclass = CL_BEQ;   aluc = ALUC_SUB; sext = 1'b1; end
            OP_BNE:  begin iclass = CL_BNE;   aluc = ALUC_SUB; sext = 1'b1; end
            OP_J:    begin iclass = CL_J;     aluc = ALUC_ADD; end
            OP_JAL:  begin iclass = CL_JAL;   aluc = ALUC_ADD; end
            default: begin iclass = CL_ILLEGAL; aluc = ALUC_ADD; end
        endcase
    end

    assign illegal = (iclass == CL_ILLEGAL);

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle CPU controller: IF/ID/EX/MEM/WB sequencer driving the shared
// ALU selects, memory/register/PC strobes and the illegal-instruction pulse.
// Outputs are decoded from the state register; pc_wr in EX also follows z
// for conditional branches. Reset forces every output to 0 in that cycle,
// so an aborted instruction never completes a write.
// Optional build macro: HAMMING_EN (enables the HAM R-type instruction).
module mc_control_unit
    import mc_cpu_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    output logic [3:0] aluc,
    output logic       alusrca,
    output logic       shift,
    output logic [1:0] alusrcb,
    output logic       sext,
    output logic       iord,
    output logic       ir_wr,
    output logic       mem_wr,
    output logic       reg_wr,
    output logic       regdst,
    output logic       jal,
    output logic       m2reg,
    output logic       pc_wr,
    output logic [1:0] pcsource,
    output logic       illegal
);

    state_t     state_r;
    state_t     next_state_s;
    iclass_t    dec_class_s;
    logic [3:0] dec_aluc_s;
    logic       dec_sext_s;
    logic       dec_illegal_s;

    mc_decoder u_decoder (
        .op      (op),
        .func    (func),
        .iclass  (dec_class_s),
        .aluc    (dec_aluc_s),
        .sext    (dec_sext_s),
        .illegal (dec_illegal_s)
    );

    // State register; reset restarts fetch
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IF;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and control outputs for the current state and class
    always_comb begin
        next_state_s = ST_IF;
        aluc     = ALUC_ADD;
        alusrca  = 1'b0;
        shift    = 1'b0;
        alusrcb  = SRCB_REG;
        sext     = 1'b0;
        iord     = 1'b0;
        ir_wr    = 1'b0;
        mem_wr   = 1'b0;
        reg_wr   = 1'b0;
        regdst   = 1'b0;
        jal      = 1'b0;
        m2reg    = 1'b0;
        pc_wr    = 1'b0;
        pcsource = PCS_ALU;
        illegal  = 1'b0;
        if (reset) begin
            next_state_s = ST_IF;
        end else begin
            case (state_r)
                ST_IF: begin
                    ir_wr        = 1'b1;
                    alusrcb      = SRCB_INC;
                    pc_wr        = 1'b1;
                    next_state_s = ST_ID;
                end
                ST_ID: begin
                    // Branch target precomputed into ALUOut
                    alusrcb = SRCB_BR;
                    sext    = 1'b1;
                    if (dec_illegal_s) begin
                        illegal      = 1'b1;
                        next_state_s = ST_IF;
                    end else begin
                        next_state_s = ST_EX;
                    end
                end
                ST_EX: begin
                    case (dec_class_s)
                        CL_R_ALU: begin
                            alusrca      = 1'b1;
                            aluc         = dec_aluc_s;
                            next_state_s = ST_WB;
                        end
                        CL_SHIFT: begin
                            alusrca      = 1'b1;
                            shift        = 1'b1;
                            aluc         = dec_aluc_s;
                            next_state_s = ST_WB;
                        end
                        CL_I_ALU: begin
                            alusrca      = 1'b1;
                            alusrcb      = SRCB_IMM;
                            sext         = dec_sext_s;
                            aluc         = dec_aluc_s;
                            next_state_s = ST_WB;
                        end
                        CL_LW, CL_SW: begin
                            alusrca      = 1'b1;
                            alusrcb      = SRCB_IMM;
                            sext         = 1'b1;
                            next_state_s = ST_MEM;
                        end
                        CL_BEQ: begin
                            alusrca      = 1'b1;
                            aluc         = ALUC_SUB;
                            pcsource     = PCS_ALUOUT;
                            pc_wr        = z;
                            next_state_s = ST_IF;
                        end
                        CL_BNE: begin
                            alusrca      = 1'b1;
                            aluc         = ALUC_SUB;
                            pcsource     = PCS_ALUOUT;
                            pc_wr        = ~z;
                            next_state_s = ST_IF;
                        end
                        CL_J: begin
                            pcsource     = PCS_JUMP;
                            pc_wr        = 1'b1;
                            next_state_s = ST_IF;
                        end
                        CL_JAL: begin
                            pcsource     = PCS_JUMP;
                            pc_wr        = 1'b1;
                            reg_wr       = 1'b1;
                            jal          = 1'b1;
                            next_state_s = ST_IF;
                        end
                        CL_JR: begin
                            pcsource     = PCS_REGA;
                            pc_wr        = 1'b1;
                            next_state_s = ST_IF;
                        end
                        default: begin
                            next_state_s = ST_IF;
                        end
                    endcase
                end
                ST_MEM: begin
                    iord = 1'b1;
                    case (dec_class_s)
                        CL_LW: begin
                            next_state_s = ST_WB;
                        end
                        CL_SW: begin
                            mem_wr       = 1'b1;
                            next_state_s = ST_IF;
                        end
                        default: begin
                            next_state_s = ST_IF;
                        end
                    endcase
                end
                ST_WB: begin
                    reg_wr       = 1'b1;
                    regdst       = (dec_class_s == CL_R_ALU) || (dec_class_s == CL_SHIFT);
                    m2reg        = (dec_class_s == CL_LW);
                    next_state_s = ST_IF;
                end
                default: begin
                    next_state_s = ST_IF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit. A reference model pushes the
// expected per-cycle control vector for each instruction into a queue; the
// vectors are popped and compared against the DUT one cycle at a time.
module tb_mc_control_unit;

    typedef struct packed {
        logic [3:0] aluc;
        logic       alusrca;
        logic       shift;
        logic [1:0] alusrcb;
        logic       sext;
        logic       iord;
        logic       ir_wr;
        logic       mem_wr;
        logic       reg_wr;
        logic       regdst;
        logic       jal;
        logic       m2reg;
        logic       pc_wr;
        logic [1:0] pcsource;
        logic       illegal;
    } ctl_t;

    localparam int K_R = 0, K_SH = 1, K_I = 2, K_LW = 3, K_SW = 4, K_BEQ = 5,
                   K_BNE = 6, K_J = 7, K_JAL = 8, K_JR = 9, K_ILL = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] func;
    logic       z;
    logic [3:0] aluc;
    logic       alusrca, shift, sext, iord, ir_wr, mem_wr, reg_wr;
    logic       regdst, jal, m2reg, pc_wr, illegal;
    logic [1:0] alusrcb, pcsource;
    ctl_t       act;

    int n_checks = 0;
    int n_fail   = 0;

    ctl_t  exp_q[$];
    string tag_q[$];

    mc_control_unit dut (
        .clock    (clock),
        .reset    (reset),
        .op       (op),
        .func     (func),
        .z        (z),
        .aluc     (aluc),
        .alusrca  (alusrca),
        .shift    (shift),
        .alusrcb  (alusrcb),
        .sext     (sext),
        .iord     (iord),
        .ir_wr    (ir_wr),
        .mem_wr   (mem_wr),
        .reg_wr   (reg_wr),
        .regdst   (regdst),
        .jal      (jal),
        .m2reg    (m2reg),
        .pc_wr    (pc_wr),
        .pcsource (pcsource),
        .illegal  (illegal)
    );

    always #5 clock = ~clock;

    assign act = {aluc, alusrca, shift, alusrcb, sext, iord, ir_wr, mem_wr,
                  reg_wr, regdst, jal, m2reg, pc_wr, pcsource, illegal};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: push the expected control vector of every cycle
    task automatic model_push(input string name, input logic [5:0] o, input logic [5:0] f, input logic zf);
        ctl_t e;
        int k;
        logic [3:0] xa;
        logic xs;
        k = K_ILL; xa = 4'b0000; xs = 1'b0;
        if (o == 6'b000000) begin
            case (f)
                6'b100000: begin k = K_R;  xa = 4'b0000; end
                6'b100010: begin k = K_R;  xa = 4'b0100; end
                6'b100100: begin k = K_R;  xa = 4'b0001; end
                6'b100101: begin k = K_R;  xa = 4'b0101; end
                6'b100110: begin k = K_R;  xa = 4'b0010; end
                6'b000000: begin k = K_SH; xa = 4'b0011; end
                6'b000010: begin k = K_SH; xa = 4'b0111; end
                6'b000011: begin k = K_SH; xa = 4'b1111; end
                6'b001000: k = K_JR;
`ifdef HAMMING_EN
                6'b111000: begin k = K_R; xa = 4'b1011; end
`else
                6'b111000: k = K_ILL;
`endif
                default:   k = K_ILL;
            endcase
        end else begin
            case (o)
                6'b001000: begin k = K_I; xa = 4'b0000; xs = 1'b1; end
                6'b001100: begin k = K_I; xa = 4'b0001; end
                6'b001101: begin k = K_I; xa = 4'b0101; end
                6'b001110: begin k = K_I; xa = 4'b0010; end
                6'b001111: begin k = K_I; xa = 4'b0110; end
                6'b100011: k = K_LW;
                6'b101011: k = K_SW;
                6'b000100: k = K_BEQ;
                6'b000101: k = K_BNE;
                6'b000010: k = K_J;
                6'b000011: k = K_JAL;
                default:   k = K_ILL;
            endcase
        end
        e = '0; e.ir_wr = 1'b1; e.pc_wr = 1'b1; e.alusrcb = 2'b01;
        exp_q.push_back(e); tag_q.push_back({name, "/IF"});
        e = '0; e.alusrcb = 2'b11; e.sext = 1'b1; e.illegal = (k == K_ILL);
        exp_q.push_back(e); tag_q.push_back({name, "/ID"});
        if (k == K_ILL) return;
        e = '0;
        case (k)
            K_R:   begin e.alusrca = 1'b1; e.aluc = xa; end
            K_SH:  begin e.alusrca = 1'b1; e.shift = 1'b1; e.aluc = xa; end
            K_I:   begin e.alusrca = 1'b1; e.alusrcb = 2'b10; e.sext = xs; e.aluc = xa; end
            K_LW, K_SW: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; e.sext = 1'b1; end
            K_BEQ: begin e.alusrca = 1'b1; e.aluc = 4'b0100; e.pcsource = 2'b01; e.pc_wr = zf; end
            K_BNE: begin e.alusrca = 1'b1; e.aluc = 4'b0100; e.pcsource = 2'b01; e.pc_wr = ~zf; end
            K_J:   begin e.pcsource = 2'b10; e.pc_wr = 1'b1; end
            K_JAL: begin e.pcsource = 2'b10; e.pc_wr = 1'b1; e.reg_wr = 1'b1; e.jal = 1'b1; end
            K_JR:  begin e.pcsource = 2'b11; e.pc_wr = 1'b1; end
            default: e = '0;
        endcase
        exp_q.push_back(e); tag_q.push_back({name, "/EX"});
        if (k == K_LW || k == K_SW) begin
            e = '0; e.iord = 1'b1; e.mem_wr = (k == K_SW);
            exp_q.push_back(e); tag_q.push_back({name, "/MEM"});
        end
        if (k == K_R || k == K_SH || k == K_I || k == K_LW) begin
            e = '0; e.reg_wr = 1'b1; e.regdst = (k == K_R || k == K_SH); e.m2reg = (k == K_LW);
            exp_q.push_back(e); tag_q.push_back({name, "/WB"});
        end
    endtask

    // Drive one instruction from its IF cycle; compare up to max_cyc cycles
    // (all of them when max_cyc < 0). A full run ends just after the
    // posedge that starts the next IF.
    task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                             input logic zf, input int max_cyc);
        int n;
        op = o; func = f; z = zf;
        model_push(name, o, f, zf);
        n = 0;
        while (exp_q.size() > 0 && (max_cyc < 0 || n < max_cyc)) begin
            @(negedge clock);
            check_eq(tag_q.pop_front(), 32'(act), 32'(exp_q.pop_front()));
            n++;
        end
        if (exp_q.size() > 0) begin
            exp_q.delete();
            tag_q.delete();
        end else begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1; op = 6'b000000; func = 6'b000000; z = 1'b0;
        @(negedge clock);
        check_eq("reset_outputs", 32'(act), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // sw interrupted by two reset clocks while in EX
        run_instr("sw_abort", 6'b101011, 6'b000000, 1'b0, 3);
        reset = 1'b1;
        #1 check_eq("rst_in_ex", 32'(act), 32'd0);
        @(negedge clock);
        check_eq("rst_cycle2", 32'(act), 32'd0);
        check_eq("rst_no_mem_wr", 32'(mem_wr), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // The first IF after reset is the IF of this instruction
        run_instr("add",  6'b000000, 6'b100000, 1'b0, -1);
        run_instr("sub",  6'b000000, 6'b100010, 1'b1, -1);
        run_instr("and",  6'b000000, 6'b100100, 1'b0, -1);
        run_instr("or",   6'b000000, 6'b100101, 1'b0, -1);
        run_instr("xor",  6'b000000, 6'b100110, 1'b0, -1);
        run_instr("sll",  6'b000000, 6'b000000, 1'b0, -1);
        run_instr("srl",  6'b000000, 6'b000010, 1'b0, -1);
        run_instr("sra",  6'b000000, 6'b000011, 1'b0, -1);
        run_instr("jr",   6'b000000, 6'b001000, 1'b0, -1);
        run_instr("ham",  6'b000000, 6'b111000, 1'b0, -1);
        run_instr("badfn",6'b000000, 6'b000001, 1'b0, -1);
        run_instr("addi", 6'b001000, 6'b100000, 1'b0, -1);
        run_instr("andi", 6'b001100, 6'b000000, 1'b0, -1);
        run_instr("ori",  6'b001101, 6'b000000, 1'b0, -1);
        run_instr("xori", 6'b001110, 6'b000000, 1'b0, -1);
        run_instr("lui",  6'b001111, 6'b000000, 1'b0, -1);
        run_instr("lw",   6'b100011, 6'b000000, 1'b0, -1);
        run_instr("sw",   6'b101011, 6'b000000, 1'b0, -1);
        run_instr("beq_z1", 6'b000100, 6'b000000, 1'b1, -1);
        run_instr("beq_z0", 6'b000100, 6'b000000, 1'b0, -1);
        run_instr("bne_z1", 6'b000101, 6'b000000, 1'b1, -1);
        run_instr("bne_z0", 6'b000101, 6'b000000, 1'b0, -1);
        run_instr("j",    6'b000010, 6'b000000, 1'b0, -1);
        run_instr("jal",  6'b000011, 6'b000000, 1'b0, -1);
        run_instr("badop",6'b111111, 6'b000000, 1'b0, -1);
        run_instr("add2", 6'b000000, 6'b100000, 1'b1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
